uart_tx_buffer: RTL

UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

---
 rtl/uart_tx_buffer_pkg.sv | 22 ++
 rtl/tx_fifo.sv | 60 ++++++
 rtl/uart_tx_buffer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/uart_tx_buffer_pkg.sv
// Shared UART definitions: transmitter FSM encodings, default baud divider and frame helpers.
// The receiver path imports the same package so both sides agree on encodings and timing.
package uart_tx_buffer_pkg;

  // 50 MHz system clock / 9600 baud
  localparam int unsigned DefaultBaudDiv = 5208;
  localparam int unsigned DataBits       = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  // Even parity: the parity bit makes the total count of ones even
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Byte FIFO feeding the UART transmitter.
// Pointers wrap modulo DEPTH; full and empty come from the occupancy count alone.
module tx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned CntW  = AddrW + 1;

  logic [7:0]       mem_q [DEPTH];
  logic [AddrW-1:0] wr_ptr_q;
  logic [AddrW-1:0] rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_ok;
  logic             pop_ok;

  // A write into a full FIFO is dropped even if a pop happens in the same cycle
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign count = count_q;
  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  // Storage array; no reset needed since pointers define which entries are valid
  always_ff @(posedge CLK) begin
    if (!RST && push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Buffered UART transmitter: a small byte FIFO drained by an 8N1/8E1 serializer.
// Frames are sent back-to-back while the FIFO has data; TX and busy are registered.
module uart_tx_buffer
  import uart_tx_buffer_pkg::*;
#(
  parameter int unsigned BAUD_DIV = DefaultBaudDiv,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PARITY   = 0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [7:0]             data_in,
  input  logic                   wr_en,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   busy,
  output logic                   TX
);

  localparam logic [15:0] BaudLast = 16'(BAUD_DIV - 1);

  tx_state_e   state_q;
  logic [15:0] baud_cnt_q;
  logic [7:0]  shift_q;
  logic [2:0]  bit_idx_q;
  logic        par_q;
  logic        baud_done;
  logic        pop;
  logic [7:0]  fifo_dout;

  assign baud_done = (baud_cnt_q == BaudLast);

  // Pop the head byte when idle, or at the last STOP cycle so the next START follows directly
  assign pop = !empty && ((state_q == StIdle) || ((state_q == StStop) && baud_done));

  tx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (wr_en),
    .pop   (pop),
    .din   (data_in),
    .dout  (fifo_dout),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Sticky record of any write dropped because the FIFO was full
  always_ff @(posedge CLK) begin
    if (RST) begin
      overflow <= 1'b0;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
    end
  end

  // Frame FSM with baud timing, shift register and registered line outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      baud_cnt_q <= '0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      par_q      <= 1'b0;
      TX         <= 1'b1;
      busy       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!empty) begin
            shift_q    <= fifo_dout;
            par_q      <= even_parity(fifo_dout);
            baud_cnt_q <= '0;
            TX         <= 1'b0;
            busy       <= 1'b1;
            state_q    <= StStart;
          end
        end
        StStart: begin
          if (baud_done) begin
            baud_cnt_q <= '0;
            TX         <= shift_q[0];
            shift_q    <= {1'b0, shift_q[7:1]};
            bit_idx_q  <= '0;
            state_q    <= StData;
          end else begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
          end
        end
        StData: begin
          if (baud_done) begin
            baud_cnt_q <= '0;
            if (bit_idx_q == 3'(DataBits - 1)) begin
              if (PARITY != 0) begin
                TX      <= par_q;
                state_q <= StParity;
              end else begin
                TX      <= 1'b1;
                state_q <= StStop;
              end
            end else begin
              TX        <= shift_q[0];
              shift_q   <= {1'b0, shift_q[7:1]};
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
          end
        end
        StParity: begin
          if (baud_done) begin
            baud_cnt_q <= '0;
            TX         <= 1'b1;
            state_q    <= StStop;
          end else begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
          end
        end
        StStop: begin
          if (baud_done) begin
            baud_cnt_q <= '0;
            if (!empty) begin
              shift_q <= fifo_dout;
              par_q   <= even_parity(fifo_dout);
              TX      <= 1'b0;
              state_q <= StStart;
            end else begin
              busy    <= 1'b0;
              state_q <= StIdle;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          TX      <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
